// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Control FSM for a shared iterative AES round datapath (one round per
//   clock). Supports AES-128/192/256 in both directions. A job is accepted on
//   the request channel. The datapath is then stepped through rounds 0..Nr,
//   and completion is reported on the response channel.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready job request handshake (ready only in IDLE)
//   req_key_size        00=128, 01=192, 10=256, 11=invalid (rejected)
//   req_decrypt         direction of the requested job
//   abort               cancels a running job (INIT/ROUND/FINAL only)
//   dp_en               datapath performs a round this cycle
//   dp_first, dp_last   round 0 / final round strobes
//   dp_round            current round number 0..Nr
//   dp_key_idx          round-key index (reversed for decrypt)
//   dp_decrypt          latched direction
//   nr_out              latched Nr of the current/last job
//   busy                high in INIT, ROUND, FINAL
//   resp_valid/ready    completion handshake
//   resp_err            job rejected (invalid key size)
//   resp_decrypt        direction of the completed job
module aes_round_sequencer #(
  parameter int ROUND_W = 4,
  parameter int NR128   = 10,
  parameter int NR192   = 12,
  parameter int NR256   = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_key_size,
  input  logic               req_decrypt,
  input  logic               abort,
  output logic               dp_en,
  output logic               dp_first,
  output logic               dp_last,
  output logic [ROUND_W-1:0] dp_round,
  output logic [ROUND_W-1:0] dp_key_idx,
  output logic               dp_decrypt,
  output logic [ROUND_W-1:0] nr_out,
  output logic               busy,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_err,
  output logic               resp_decrypt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_RESP
  } state_t;

  localparam logic [ROUND_W-1:0] NR128_W = ROUND_W'(NR128);
  localparam logic [ROUND_W-1:0] NR192_W = ROUND_W'(NR192);
  localparam logic [ROUND_W-1:0] NR256_W = ROUND_W'(NR256);
  localparam logic [ROUND_W-1:0] ONE_W   = ROUND_W'(1);

  state_t             state, state_next;
  logic [ROUND_W-1:0] round_cnt, round_cnt_next;
  logic [ROUND_W-1:0] nr, nr_next;
  logic               decrypt, decrypt_next;
  logic               err, err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      round_cnt <= '0;
      nr        <= '0;
      decrypt   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      round_cnt <= round_cnt_next;
      nr        <= nr_next;
      decrypt   <= decrypt_next;
      err       <= err_next;
    end
  end

  always_comb begin
    state_next     = state;
    round_cnt_next = round_cnt;
    nr_next        = nr;
    decrypt_next   = decrypt;
    err_next       = err;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          decrypt_next   = req_decrypt;
          round_cnt_next = '0;
          err_next       = 1'b0;
          state_next     = S_INIT;
          case (req_key_size)
            2'b00:   nr_next = NR128_W;
            2'b01:   nr_next = NR192_W;
            2'b10:   nr_next = NR256_W;
            default: begin
              // Rejected job: report straight away, datapath never touched.
              nr_next    = '0;
              err_next   = 1'b1;
              state_next = S_RESP;
            end
          endcase
        end
      end
      S_INIT: begin
        // Nr is at least 10, so INIT always goes through ROUND.
        round_cnt_next = ONE_W;
        state_next     = S_ROUND;
      end
      S_ROUND: begin
        round_cnt_next = round_cnt + ONE_W;
        if (round_cnt == nr - ONE_W) state_next = S_FINAL;
      end
      S_FINAL: begin
        state_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next     = S_IDLE;
          round_cnt_next = '0;
        end
      end
      default: begin
        state_next     = S_IDLE;
        round_cnt_next = '0;
      end
    endcase

    // Abort overrides every busy-state transition, including FINAL->RESP.
    if (abort && (state == S_INIT || state == S_ROUND || state == S_FINAL)) begin
      state_next     = S_IDLE;
      round_cnt_next = '0;
    end
  end

  // Outputs are decoded from state so they drop as soon as reset asserts.
  always_comb begin
    busy         = (state == S_INIT) || (state == S_ROUND) || (state == S_FINAL);
    req_ready    = (state == S_IDLE);
    dp_en        = busy;
    dp_first     = (state == S_INIT);
    dp_last      = (state == S_FINAL);
    dp_round     = busy ? round_cnt : '0;
    dp_key_idx   = '0;
    if (busy) dp_key_idx = decrypt ? (nr - round_cnt) : round_cnt;
    dp_decrypt   = (busy || state == S_RESP) ? decrypt : 1'b0;
    nr_out       = nr;
    resp_valid   = (state == S_RESP);
    resp_err     = (state == S_RESP) ? err : 1'b0;
    resp_decrypt = (state == S_RESP) ? decrypt : 1'b0;
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer: a vector table of whole jobs (checked
// cycle by cycle against a round/key-index model) plus hand-written
// sequences for abort, abort-vs-final, abort-in-RESP and mid-job reset.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_key_size;
  logic       req_decrypt;
  logic       abort;
  logic       dp_en, dp_first, dp_last;
  logic [3:0] dp_round, dp_key_idx, nr_out;
  logic       dp_decrypt, busy;
  logic       resp_valid, resp_ready, resp_err, resp_decrypt;

  int checks = 0;
  int errors = 0;

  aes_round_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key_size(req_key_size), .req_decrypt(req_decrypt),
    .abort(abort),
    .dp_en(dp_en), .dp_first(dp_first), .dp_last(dp_last),
    .dp_round(dp_round), .dp_key_idx(dp_key_idx),
    .dp_decrypt(dp_decrypt), .nr_out(nr_out), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_err(resp_err), .resp_decrypt(resp_decrypt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] key_size;
    logic       decrypt;
    int         exp_nr;
    logic       exp_err;
    int         resp_delay;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the request fields to
  // show they are ignored once the job is running.
  task automatic send_req(input logic [1:0] ks, input logic dec);
    req_valid    = 1'b1;
    req_key_size = ks;
    req_decrypt  = dec;
    tick();
    req_valid    = 1'b0;
    req_key_size = ~ks;
    req_decrypt  = ~dec;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("req_ready_after_resp", 32'(req_ready), 1);
    check("resp_valid_after_resp", 32'(resp_valid), 0);
  endtask

  task automatic run_job(input logic [1:0] ks, input logic dec, input int exp_nr,
                         input logic exp_err, input int resp_delay);
    int exp_key;
    check("req_ready_idle", 32'(req_ready), 1);
    send_req(ks, dec);
    if (exp_err) begin
      check("err_resp_valid", 32'(resp_valid), 1);
      check("err_resp_err", 32'(resp_err), 1);
      check("err_dp_en", 32'(dp_en), 0);
      check("err_nr_out", 32'(nr_out), 0);
      check("err_busy", 32'(busy), 0);
    end else begin
      for (int k = 0; k <= exp_nr; k++) begin
        exp_key = dec ? (exp_nr - k) : k;
        check("dp_en", 32'(dp_en), 1);
        check("dp_round", 32'(dp_round), 32'(k));
        check("dp_key_idx", 32'(dp_key_idx), 32'(exp_key));
        check("dp_first", 32'(dp_first), (k == 0) ? 1 : 0);
        check("dp_last", 32'(dp_last), (k == exp_nr) ? 1 : 0);
        check("dp_decrypt", 32'(dp_decrypt), 32'(dec));
        check("busy", 32'(busy), 1);
        check("req_ready_busy", 32'(req_ready), 0);
        check("resp_valid_busy", 32'(resp_valid), 0);
        tick();
      end
      check("resp_valid", 32'(resp_valid), 1);
      check("resp_err", 32'(resp_err), 0);
      check("resp_decrypt", 32'(resp_decrypt), 32'(dec));
      check("nr_out", 32'(nr_out), 32'(exp_nr));
      check("dp_en_resp", 32'(dp_en), 0);
    end
    for (int d = 0; d < resp_delay; d++) begin
      tick();
      check("resp_valid_held", 32'(resp_valid), 1);
      check("req_ready_held", 32'(req_ready), 0);
    end
    release_resp();
    $display("job key_size=%0d decrypt=%0d nr=%0d err=%0d delay=%0d done",
             ks, dec, exp_nr, exp_err, resp_delay);
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 10, 1'b0, 0};
    vecs[1] = '{2'b10, 1'b1, 14, 1'b0, 0};
    vecs[2] = '{2'b11, 1'b0, 0,  1'b1, 0};
    vecs[3] = '{2'b01, 1'b0, 12, 1'b0, 5};
    vecs[4] = '{2'b00, 1'b1, 10, 1'b0, 1};
    vecs[5] = '{2'b01, 1'b1, 12, 1'b0, 0};
    vecs[6] = '{2'b10, 1'b0, 14, 1'b0, 2};

    rst_n = 1'b0; req_valid = 1'b0; req_key_size = 2'b00; req_decrypt = 1'b0;
    abort = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_dp_en", 32'(dp_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_nr_out", 32'(nr_out), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_dp_round", 32'(dp_round), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      run_job(vecs[i].key_size, vecs[i].decrypt, vecs[i].exp_nr,
              vecs[i].exp_err, vecs[i].resp_delay);

    // Abort at round 6 of AES-128, then a normal job.
    send_req(2'b00, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    check("abort_pre_round", 32'(dp_round), 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_dp_en", 32'(dp_en), 0);
    check("abort_req_ready", 32'(req_ready), 1);
    for (int k = 0; k < 8; k++) begin
      check("abort_no_resp", 32'(resp_valid), 0);
      tick();
    end
    $display("job abort at round 6 done");
    run_job(2'b00, 1'b0, 10, 1'b0, 0);

    // Abort coinciding with the dp_last cycle: abort wins.
    send_req(2'b00, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    check("abort_last_strobe", 32'(dp_last), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_last_no_resp", 32'(resp_valid), 0);
    check("abort_last_req_ready", 32'(req_ready), 1);
    $display("job abort at final round done");

    // Abort in RESP is ignored.
    send_req(2'b00, 1'b0);
    for (int k = 0; k < 11; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_resp_kept", 32'(resp_valid), 1);
    release_resp();
    $display("job abort during response done");

    // Asynchronous reset at round 4 of AES-192.
    send_req(2'b01, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("rst_mid_round", 32'(dp_round), 4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_dp_en", 32'(dp_en), 0);
    check("rst_mid_req_ready", 32'(req_ready), 1);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_nr_out", 32'(nr_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("job reset at round 4 done");
    run_job(2'b01, 1'b0, 12, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Controller that sequences one shared iterative AES round datapath: one round per clock, for AES-128/192/256, encrypt or decrypt. Accepts a job over a valid/ready request channel and drives the datapath strobes, round number and round-key index. Returns completion over a valid/ready response channel. Sits between the system-level mode/switch logic and the Cipher/DeCipher round datapath; the KeyExpansion word arrays are indexed by dp_key_idx.

Parameters:
ROUND_W, 4, width of round counter and key index (must hold 0..14)
NR128, 10, round count for key_size 2'b00
NR192, 12, round count for key_size 2'b01
NR256, 14, round count for key_size 2'b10

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  job request
req_ready  out  1  high only in IDLE
req_key_size  in  2  00=128, 01=192, 10=256, 11=invalid
req_decrypt  in  1  0=encrypt, 1=decrypt
abort  in  1  synchronous job cancel
dp_en  out  1  datapath performs a round this cycle
dp_first  out  1  round 0 (load input + AddRoundKey only)
dp_last  out  1  final round (no MixColumns / InvMixColumns); datapath captures result
dp_round  out  ROUND_W  current round number 0..Nr
dp_key_idx  out  ROUND_W  round-key index into expanded words
dp_decrypt  out  1  latched direction
nr_out  out  ROUND_W  latched Nr of current/last job
busy  out  1  high in INIT, ROUND, FINAL
resp_valid  out  1  job complete
resp_ready  in  1  consumer accepts response
resp_err  out  1  job rejected (invalid key size)
resp_decrypt  out  1  direction of completed job

Behaviour:
- Reset (rst_n low, any time incl. mid-job): state IDLE; all outputs 0 except req_ready=1; round counter 0; nr_out=0; datapath strobes deasserted immediately (async).
- States: IDLE, INIT, ROUND, FINAL, RESP.
- IDLE: req_ready=1. On req_valid at edge: latch key_size->Nr, req_decrypt. Valid size -> INIT; size 11 -> RESP with resp_err=1, no dp_en ever asserted.
- INIT (1 cycle): dp_en=1, dp_first=1, dp_round=0. -> ROUND (or FINAL never direct; Nr>=10).
- ROUND: dp_en=1, dp_round=r for r=1..Nr-1, one per cycle; after r=Nr-1 -> FINAL.
- FINAL (1 cycle): dp_en=1, dp_last=1, dp_round=Nr. -> RESP.
- dp_key_idx: encrypt = dp_round; decrypt = Nr - dp_round (Nr..0). Only meaningful while dp_en=1; 0 otherwise.
- RESP: resp_valid=1, resp_err, resp_decrypt stable; held until resp_ready sampled high, then IDLE (req_ready=1 next cycle; no same-cycle re-accept).
- Latency: request accepted at edge T -> dp_first during T+1, dp_last during T+Nr+1, resp_valid from T+Nr+2. Invalid size: resp_valid from T+1.
- abort: sampled in INIT/ROUND/FINAL -> IDLE next edge, no response, strobes 0. Ignored in IDLE and RESP (abort does not drop a pending response). abort with dp_last cycle: abort wins, no RESP.
- busy = state in {INIT, ROUND, FINAL}. dp_decrypt valid while busy or in RESP.
- Counter never exceeds Nr; arithmetic ROUND_W bits unsigned, no wrap possible for legal Nr.
- req_key_size/req_decrypt changes while not IDLE have no effect.

Test Plan:
- AES-128 encrypt, req at T -> dp_round 0..10 in T+1..T+11, dp_key_idx 0..10, dp_first only at T+1, dp_last only at T+11, resp_valid at T+12, resp_err=0.
- AES-256 decrypt -> 15 dp_en cycles, dp_key_idx 14,13..0, dp_last at T+15, resp_valid at T+16, resp_decrypt=1.
- key_size=11 -> resp_valid=1, resp_err=1 at T+1, dp_en never high, nr_out=0.
- AES-192 encrypt, resp_ready low 5 cycles -> resp_valid held, req_ready=0 throughout; ready high -> IDLE next cycle, req_ready=1.
- Abort at dp_round=6 (AES-128) -> next cycle IDLE, dp_en=0, no resp_valid; subsequent AES-128 job completes with normal 12-cycle latency.
- rst_n low at dp_round=4 of AES-192 -> all strobes 0 immediately, req_ready=1; release then new job runs correctly.
